// File: rtl/wb_fetch_queue_if.sv
// Pipelined Wishbone B4 read port used by the instruction prefetch queue.
// The master drives the request side; the slave returns stall/ack/err/data.
interface wb_fetch_queue_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_adr_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stall_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [31:0] wb_dat_i;

  // Handshake: a request is accepted on any rising edge with stb=1 and
  // stall=0; every accepted request receives exactly one ack or err, in order.
  modport master (
    output wb_cyc_o, wb_stb_o, wb_adr_o, wb_we_o, wb_sel_o,
    input  wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_we_o, wb_sel_o,
    output wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i
  );
endinterface

// File: rtl/wb_fetch_queue.sv
// Instruction prefetch queue: issues pipelined Wishbone reads and buffers the
// returned words in a FIFO; redirects flush it and drop stale responses.
module wb_fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  new_pc_en_i,
  input  logic [31:0]           new_pc_i,
  input  logic                  stall_i,
  output logic                  valid_o,
  output logic [31:0]           instr_o,
  output logic [31:0]           pc_o,
  output logic                  err_o,
  wb_fetch_queue_if.master      wb
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = AW + 2;
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] SUM_DEPTH = SW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   tag_pc_q, tag_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          halt_q, halt_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic          err_mem_q   [DEPTH];

  logic [AW:0]   occ;
  logic [SW-1:0] reserved;
  logic          empty;
  logic          resp;
  logic          stb;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   target_pc;

  assign occ       = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign target_pc = new_pc_i & 32'hFFFF_FFFC;
  // Occupancy plus responses still owed to the FIFO; never let it exceed DEPTH.
  assign reserved  = SW'(occ) + SW'(out_q) - SW'(discard_q);

  // Responses are only meaningful while something is outstanding.
  assign resp   = (wb.wb_ack_i || wb.wb_err_i) && (out_q != '0);
  // The strobe is withdrawn during a redirect so no request is accepted at
  // the old address in the cycle the discard count is captured.
  assign stb    = !rst_i && !new_pc_en_i && !halt_q &&
                  (out_q < CNT_MAX) && (reserved < SUM_DEPTH);
  assign accept = stb && !wb.wb_stall_i;
  assign push   = resp && (discard_q == '0) && !new_pc_en_i;
  assign pop    = !empty && !stall_i && !new_pc_en_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    out_d      = out_q;
    discard_d  = discard_q;
    halt_d     = halt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      out_d      = out_q + CNT_ONE;
    end
    if (resp) begin
      out_d = out_d - CNT_ONE;
      if (discard_q != '0) discard_d = discard_q - CNT_ONE;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      tag_pc_d = tag_pc_q + 32'd4;
      if (wb.wb_err_i) halt_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (new_pc_en_i) begin
      fetch_pc_d = target_pc;
      tag_pc_d   = target_pc;
      discard_d  = out_q - CW'(resp);
      halt_d     = 1'b0;
      rd_ptr_d   = wr_ptr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= RESET_PC;
      out_q      <= '0;
      discard_q  <= '0;
      halt_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
        err_mem_q[i]   <= 1'b0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_pc_q   <= tag_pc_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      halt_q     <= halt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push) begin
        instr_mem_q[wr_ptr_q[AW-1:0]] <= wb.wb_dat_i;
        pc_mem_q[wr_ptr_q[AW-1:0]]    <= tag_pc_q;
        err_mem_q[wr_ptr_q[AW-1:0]]   <= wb.wb_err_i;
      end
    end
  end

  assign valid_o = !empty;
  assign instr_o = instr_mem_q[rd_ptr_q[AW-1:0]];
  assign pc_o    = pc_mem_q[rd_ptr_q[AW-1:0]];
  assign err_o   = err_mem_q[rd_ptr_q[AW-1:0]];

  assign wb.wb_stb_o = stb;
  assign wb.wb_adr_o = stb ? fetch_pc_q : 32'h0;
  // Cycle stays up while stale responses drain after a redirect.
  assign wb.wb_cyc_o = stb || (out_q != '0);
  assign wb.wb_we_o  = 1'b0;
  assign wb.wb_sel_o = 4'hF;

endmodule

// File: tb/tb_wb_fetch_queue.sv
// Bench for wb_fetch_queue: cycle table for streaming/backpressure, then
// hand sequences for redirects, bus error, wrap-around and alignment.
module tb_wb_fetch_queue;

  localparam logic [31:0] DAT_KEY = 32'hC0DE_0000;
  localparam logic [31:0] NO_ERR  = 32'h0000_0001;

  logic        clk;
  logic        rst;
  logic        new_pc_en;
  logic [31:0] new_pc;
  logic        stall;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        err;

  wb_fetch_queue_if wb_if ();

  wb_fetch_queue #(
    .DEPTH(4),
    .MAX_OUTSTANDING(2),
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .new_pc_en_i(new_pc_en),
    .new_pc_i(new_pc),
    .stall_i(stall),
    .valid_o(valid),
    .instr_o(instr),
    .pc_o(pc),
    .err_o(err),
    .wb(wb_if)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- slave model ----------------
  typedef struct {
    logic [31:0] adr;
    int          cnt;
  } slv_req_t;

  slv_req_t    slv_q[$];
  int          slv_lat;
  logic [31:0] slv_err_adr;
  bit          acc_seen;
  bit          resp_seen;
  logic [31:0] acc_adr;

  initial begin
    slv_req_t r;
    wb_if.wb_stall_i = 1'b0;
    wb_if.wb_ack_i   = 1'b0;
    wb_if.wb_err_i   = 1'b0;
    wb_if.wb_dat_i   = 32'h0;
    acc_seen  = 1'b0;
    resp_seen = 1'b0;
    acc_adr   = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        slv_q.delete();
        wb_if.wb_ack_i = 1'b0;
        wb_if.wb_err_i = 1'b0;
        wb_if.wb_dat_i = 32'h0;
      end else begin
        if (resp_seen && slv_q.size() > 0) slv_q.delete(0);
        foreach (slv_q[i]) if (slv_q[i].cnt > 0) slv_q[i].cnt = slv_q[i].cnt - 1;
        if (acc_seen) begin
          r.adr = acc_adr;
          r.cnt = slv_lat - 1;
          slv_q.push_back(r);
        end
        if (slv_q.size() > 0 && slv_q[0].cnt == 0) begin
          wb_if.wb_ack_i = (slv_q[0].adr != slv_err_adr);
          wb_if.wb_err_i = (slv_q[0].adr == slv_err_adr);
          wb_if.wb_dat_i = slv_q[0].adr ^ DAT_KEY;
        end else begin
          wb_if.wb_ack_i = 1'b0;
          wb_if.wb_err_i = 1'b0;
        end
      end
      #4;
      acc_seen  = wb_if.wb_stb_o && !wb_if.wb_stall_i;
      acc_adr   = wb_if.wb_adr_o;
      resp_seen = wb_if.wb_ack_i || wb_if.wb_err_i;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks;
  int          n_pass;
  int          cyc_low;
  logic [31:0] err_pc;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic check_reset(input string name);
    chkb({name, " valid"}, valid, 1'b0);
    chk({name, " instr"}, instr, 32'h0);
    chk({name, " pc"}, pc, 32'h0);
    chkb({name, " err"}, err, 1'b0);
    chkb({name, " cyc"}, wb_if.wb_cyc_o, 1'b0);
    chkb({name, " stb"}, wb_if.wb_stb_o, 1'b0);
    chk({name, " adr"}, wb_if.wb_adr_o, 32'h0);
    chkb({name, " we"}, wb_if.wb_we_o, 1'b0);
  endtask

  // Pops every pc in exp_q in order, waiting a bounded time for each.
  task automatic check_stream(input string name);
    logic [31:0] e;
    int waited;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      waited = 0;
      do begin
        @(negedge clk);
        #1;
        waited++;
        if (!wb_if.wb_cyc_o) cyc_low++;
      end while (!valid && waited < 30);
      chkb($sformatf("%s valid@%08h", name, e), valid, 1'b1);
      chk($sformatf("%s pc", name), pc, e);
      chk($sformatf("%s instr@%08h", name, e), instr, e ^ DAT_KEY);
      chkb($sformatf("%s err@%08h", name, e), err, (e == err_pc));
    end
  endtask

  task automatic do_reset(input int lat);
    @(negedge clk);
    stall     = 1'b0;
    new_pc_en = 1'b0;
    rst       = 1'b1;
    #1;
    check_reset("midrst");
    slv_lat     = lat;
    slv_err_adr = NO_ERR;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic redir(input logic [31:0] target);
    new_pc    = target;
    new_pc_en = 1'b1;
    @(negedge clk);
    new_pc_en = 1'b0;
    #1;
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    bit          stall;
    bit          valid;
    logic [31:0] pc;
    bit          stb;
    logic [31:0] adr;
    bit          cyc;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int stb_seen;
    rst = 1'b1; new_pc_en = 1'b0; new_pc = 32'h0; stall = 1'b0;
    n_checks = 0; n_pass = 0; cyc_low = 0;
    slv_lat = 1; slv_err_adr = NO_ERR; err_pc = NO_ERR;

    // zero-wait streaming, then stall until the FIFO is full, then release
    vecs[0]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h100, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h104, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h100, 1'b1, 32'h108, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'h104, 1'b1, 32'h10C, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h110, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h114, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h118, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'h10C, 1'b0, 32'h000, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 32'h10C, 1'b0, 32'h000, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h10C, 1'b0, 32'h000, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h10C, 1'b0, 32'h000, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h11C, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h114, 1'b1, 32'h120, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 32'h118, 1'b1, 32'h124, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 32'h11C, 1'b1, 32'h128, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 32'h120, 1'b1, 32'h12C, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      stall = vecs[i].stall;
      #1;
      chkb($sformatf("vec%0d valid", i), valid, vecs[i].valid);
      chk($sformatf("vec%0d pc", i), pc, vecs[i].pc);
      chk($sformatf("vec%0d instr", i), instr, vecs[i].valid ? (vecs[i].pc ^ DAT_KEY) : 32'h0);
      chkb($sformatf("vec%0d stb", i), wb_if.wb_stb_o, vecs[i].stb);
      if (vecs[i].stb) chk($sformatf("vec%0d adr", i), wb_if.wb_adr_o, vecs[i].adr);
      chkb($sformatf("vec%0d cyc", i), wb_if.wb_cyc_o, vecs[i].cyc);
    end

    // redirect with two requests in flight on a 3-cycle slave
    do_reset(3);
    chk("s2 adr0", wb_if.wb_adr_o, 32'h100);
    @(negedge clk); #1;
    chk("s2 adr1", wb_if.wb_adr_o, 32'h104);
    @(negedge clk); #1;
    chkb("s2 stb at max outstanding", wb_if.wb_stb_o, 1'b0);
    redir(32'h2000);
    chkb("s2 stb still at max", wb_if.wb_stb_o, 1'b0);
    chkb("s2 cyc held", wb_if.wb_cyc_o, 1'b1);
    @(negedge clk); #1;
    chkb("s2 stb new target", wb_if.wb_stb_o, 1'b1);
    chk("s2 adr new target", wb_if.wb_adr_o, 32'h2000);
    cyc_low = 0;
    exp_q = '{32'h2000, 32'h2004, 32'h2008};
    check_stream("s2");
    chk("s2 cyc low cycles", 32'(cyc_low), 32'h0);

    // redirect in the same cycle as the ack for 0x100
    do_reset(1);
    @(negedge clk);
    redir(32'h40);
    chkb("s3 stb", wb_if.wb_stb_o, 1'b1);
    chk("s3 adr", wb_if.wb_adr_o, 32'h40);
    chkb("s3 no stale valid", valid, 1'b0);
    exp_q = '{32'h40, 32'h44, 32'h48};
    check_stream("s3");

    // bus error on 0x10C halts fetching until a redirect
    do_reset(1);
    slv_err_adr = 32'h10C;
    err_pc      = 32'h10C;
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    check_stream("s4");
    chkb("s4 halted stb", wb_if.wb_stb_o, 1'b0);
    exp_q = '{32'h110};
    check_stream("s4 tail");
    stb_seen = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (wb_if.wb_stb_o) stb_seen++;
    end
    chk("s4 strobes while halted", 32'(stb_seen), 32'h0);
    chkb("s4 drained", valid, 1'b0);
    slv_err_adr = NO_ERR;
    err_pc      = NO_ERR;
    redir(32'h0);
    chkb("s4 resume stb", wb_if.wb_stb_o, 1'b1);
    chk("s4 resume adr", wb_if.wb_adr_o, 32'h0);
    exp_q = '{32'h0, 32'h4};
    check_stream("s4 resume");

    // wrap-around and alignment of the redirect target
    redir(32'hFFFF_FFFC);
    chkb("wrap stb", wb_if.wb_stb_o, 1'b1);
    chk("wrap adr0", wb_if.wb_adr_o, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap adr1", wb_if.wb_adr_o, 32'h0);
    exp_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    check_stream("wrap");
    redir(32'h203);
    chkb("align stb", wb_if.wb_stb_o, 1'b1);
    chk("align adr", wb_if.wb_adr_o, 32'h200);
    exp_q = '{32'h200, 32'h204};
    check_stream("align");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
